// File: rtl/pipeline_fetch.sv
// Instruction fetch front end: owns the PC, drives a 1-cycle-latency imem and presents one
// instruction per cycle to decode, with stall, redirect and HALT handling.
module pipeline_fetch #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     IR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [IR_W-1:0] NOP_IR   = '0,
  parameter logic [2:0]      HALT_OPC = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [IR_W-1:0] IR_out,
  output logic [PC_W-1:0] PC_out,
  output logic            valid_out,
  output logic            flush_1out,
  output logic            halted,
  output logic [15:0]     fetch_count
);

  typedef enum logic [1:0] {StFill, StRun, StHalt} state_e;

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     count_q, count_d;
  logic            is_halt_op;

  assign is_halt_op = (IR_out[IR_W-1 -: 3] == HALT_OPC);

  // Stall re-reads pc_q so imem_rdata stays stable while decode holds.
  always_comb begin
    imem_addr = pc_q + PcOne;
    if (redirect_valid) begin
      imem_addr = redirect_pc;
    end else if (state_q != StRun) begin
      imem_addr = pc_q;
    end else if (stall) begin
      imem_addr = pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: state_d = redirect_valid ? StFill : StRun;
      StRun: begin
        if (redirect_valid) begin
          state_d = StFill;
        end else if (!stall && is_halt_op) begin
          state_d = StHalt;
        end
      end
      StHalt: if (redirect_valid) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (state_q == StRun && !stall && !redirect_valid && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= imem_addr;
      count_q <= count_d;
    end
  end

  always_comb begin
    valid_out = (state_q == StRun);
    IR_out    = valid_out ? imem_rdata : NOP_IR;
  end

  assign PC_out      = pc_q;
  assign flush_1out  = ~valid_out;
  assign halted      = (state_q == StHalt);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: an imem model plus a reference model of what decode should see,
// driven by directed scenarios and random stall/redirect traffic.
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] IR_out;
  logic [7:0]  PC_out;
  logic        valid_out;
  logic        flush_1out;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  // Reference: the instruction decode sees, whether it is real, halted flag, accepted count.
  logic        m_valid;
  logic        m_halted;
  logic [7:0]  m_pc;
  logic [15:0] m_count;

  pipeline_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .IR_out         (IR_out),
    .PC_out         (PC_out),
    .valid_out      (valid_out),
    .flush_1out     (flush_1out),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [42:0] obs_vec();
    return {valid_out, flush_1out, halted, PC_out, IR_out, fetch_count};
  endfunction

  function automatic logic [42:0] exp_vec();
    return {m_valid, !m_valid, m_halted, m_pc, (m_valid ? mem[m_pc] : 16'h0000), m_count};
  endfunction

  function automatic logic [7:0] exp_addr();
    if (redirect_valid) return redirect_pc;
    if (m_valid && !stall) return m_pc + 8'd1;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_pc     = 8'h00;
    m_count  = 16'h0000;
  endtask

  // One clock of decode-visible behaviour given this cycle's inputs.
  task automatic model_tick();
    if (redirect_valid) begin
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_pc     = redirect_pc;
    end else if (m_halted) begin
      m_pc = m_pc;
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!stall) begin
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (mem[m_pc][15:13] == 3'b111) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [7:0] t);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = t;
    #1;
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [7:0] t);
    drive(1'b0, 1'b1, t);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec() || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: got %h/%h expected %h/00", obs_vec(), imem_addr, exp_vec());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || flush_1out !== 1'b1 || PC_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_cycle1: got v=%b f=%b pc=%h expected v=0 f=1 pc=00",
               valid_out, flush_1out, PC_out);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({valid_out, PC_out, IR_out} !== {1'b1, 8'(k), 16'h1000 + 16'(k)}) begin
        errors++;
        $display("FAIL reset_first_%0d: got v=%b pc=%h ir=%h expected v=1 pc=%h ir=%h", k,
                 valid_out, PC_out, IR_out, 8'(k), 16'h1000 + 16'(k));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model_%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10 && !(m_valid && m_pc == 8'h05); i++) tick();
    checks++;
    if (PC_out !== 8'h05 || fetch_count !== 16'd5) begin
      errors++;
      $display("FAIL stall_setup: got pc=%h cnt=%0d expected pc=05 cnt=5", PC_out, fetch_count);
    end
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== 8'h05) begin
        errors++;
        $display("FAIL stall_addr_%0d: got %h expected 05", i, imem_addr);
      end
      tick();
      checks++;
      if ({valid_out, PC_out, IR_out, fetch_count} !== {1'b1, 8'h05, 16'h1005, 16'd5}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h ir=%h cnt=%0d expected 1/05/1005/5", i,
                 valid_out, PC_out, IR_out, fetch_count);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (PC_out !== 8'h06 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_redirect();
    go_to(8'h10);
    drive(1'b0, 1'b1, 8'h40);
    tick();
    checks++;
    if (valid_out !== 1'b0 || flush_1out !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL redirect_bubble: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({valid_out, PC_out, IR_out} !== {1'b1, 8'h40 + 8'(k), 16'h1040 + 16'(k)} ||
          obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL redirect_target_%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_redirect_stall();
    go_to(8'h20);
    drive(1'b1, 1'b1, 8'h30);
    checks++;
    if (imem_addr !== 8'h30) begin
      errors++;
      $display("FAIL redir_stall_addr: got %h expected 30", imem_addr);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL redir_stall_bubble: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if ({valid_out, PC_out, IR_out} !== {1'b1, 8'h30, 16'h1030}) begin
      errors++;
      $display("FAIL redir_stall_target: got v=%b pc=%h ir=%h expected 1/30/1030",
               valid_out, PC_out, IR_out);
    end
  endtask

  task automatic test_halt();
    logic [15:0] cnt;
    go_to(8'h05);
    tick();
    tick();
    cnt = m_count;
    checks++;
    if ({valid_out, PC_out, IR_out} !== {1'b1, 8'h07, 16'hE000}) begin
      errors++;
      $display("FAIL halt_deliver: got v=%b pc=%h ir=%h expected 1/07/e000",
               valid_out, PC_out, IR_out);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || valid_out !== 1'b0 || fetch_count !== cnt + 16'd1 ||
          obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL halt_hold_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    go_to(8'h00);
    checks++;
    if ({halted, valid_out, PC_out, IR_out} !== {1'b0, 1'b1, 8'h00, 16'h1000}) begin
      errors++;
      $display("FAIL halt_resume: got h=%b v=%b pc=%h ir=%h expected 0/1/00/1000",
               halted, valid_out, PC_out, IR_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    go_to(8'hFE);
    want = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid_out !== 1'b1 || PC_out !== want || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_%0d: got v=%b pc=%h expected v=1 pc=%h", k, valid_out, PC_out, want);
      end
      tick();
      want = want + 8'd1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 8) == 0, 8'($urandom));
      checks++;
      if (imem_addr !== exp_addr()) begin
        errors++;
        $display("FAIL rand_addr_%0d: got %h expected %h", i, imem_addr, exp_addr());
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_out_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    go_to(8'h30);
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({valid_out, flush_1out, halted, PC_out, IR_out, fetch_count, imem_addr} !==
        {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: got %h addr=%h expected %h addr=00",
               obs_vec(), imem_addr, exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tick();
    checks++;
    if ({valid_out, PC_out, IR_out, fetch_count} !== {1'b1, 8'h00, 16'h1000, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset_restart: got v=%b pc=%h ir=%h cnt=%0d expected 1/00/1000/0",
               valid_out, PC_out, IR_out, fetch_count);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
    mem[7] = 16'hE000;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
